// File: rtl/fb_cmd_writer.sv
// fb_cmd_writer
//   Decodes a byte-serial command stream into framebuffer writes.
//   Burst-write packet: HDR_WRITE, ADDR_HI, ADDR_LO, LEN, LEN data bytes.
//   Fill packet:        HDR_FILL,  ADDR_HI, ADDR_LO, LEN, fill byte; the fill
//                       byte is then written to LEN consecutive addresses.
//   LEN of 0 means 256. Addresses wrap at 16'hFFFF.
// Ports
//   clk, rst_n         clock, async active-low reset
//   rx_data, rx_new    received byte + one-cycle valid strobe
//   addrW, dataW, wrW  framebuffer write port (wrW is a one-cycle strobe)
//   busy               packet in progress (FSM not idle)
//   err                one-cycle pulse on timeout or byte overrun during fill
//   pkt_done           one-cycle pulse coincident with the last write
module fb_cmd_writer #(
  parameter int          TIMEOUT   = 50000,
  parameter logic [7:0]  HDR_WRITE = 8'hA5,
  parameter logic [7:0]  HDR_FILL  = 8'hA6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_new,
  output logic [15:0] addrW,
  output logic [7:0]  dataW,
  output logic        wrW,
  output logic        busy,
  output logic        err,
  output logic        pkt_done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR_HI  = 3'd1;
  localparam logic [2:0] ADDR_LO  = 3'd2;
  localparam logic [2:0] LEN      = 3'd3;
  localparam logic [2:0] DATA     = 3'd4;
  localparam logic [2:0] FILL_VAL = 3'd5;
  localparam logic [2:0] FILL     = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic          mode_fill;
  logic [15:0]   addr;
  logic [8:0]    cnt;        // 1..256 remaining writes
  logic [7:0]    fill_val;
  logic [TW-1:0] tmo;

  logic timed, tmo_hit, beat;

  // Inter-byte timeout only guards states that wait on the host.
  assign timed   = (state == ADDR_HI) || (state == ADDR_LO) || (state == LEN) ||
                   (state == DATA)    || (state == FILL_VAL);
  // Counter would reach TIMEOUT on this edge with no byte arriving.
  assign tmo_hit = timed && !rx_new && (tmo == TW'(TIMEOUT - 1));
  // A write beat: one per received byte in DATA, one per cycle in FILL.
  assign beat    = (state == FILL) || ((state == DATA) && rx_new);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_fill <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
      fill_val  <= '0;
      tmo       <= '0;
      addrW     <= '0;
      dataW     <= '0;
      wrW       <= 1'b0;
      err       <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      wrW      <= 1'b0;
      err      <= 1'b0;
      pkt_done <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_new) begin
            if (rx_data == HDR_WRITE) begin
              state     <= ADDR_HI;
              mode_fill <= 1'b0;
            end else if (rx_data == HDR_FILL) begin
              state     <= ADDR_HI;
              mode_fill <= 1'b1;
            end
          end
        end
        ADDR_HI: if (rx_new) begin
          addr[15:8] <= rx_data;
          state      <= ADDR_LO;
        end
        ADDR_LO: if (rx_new) begin
          addr[7:0] <= rx_data;
          state     <= LEN;
        end
        LEN: if (rx_new) begin
          cnt   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          state <= mode_fill ? FILL_VAL : DATA;
        end
        FILL_VAL: if (rx_new) begin
          fill_val <= rx_data;
          state    <= FILL;
        end
        DATA, FILL: begin
          // A byte arriving while the fill runs is dropped and flagged.
          if (state == FILL && rx_new) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (beat) begin
        wrW   <= 1'b1;
        addrW <= addr;
        dataW <= (state == FILL) ? fill_val : rx_data;
        addr  <= addr + 16'd1;
        cnt   <= cnt - 9'd1;
        if (cnt == 9'd1) begin
          pkt_done <= 1'b1;
          state    <= IDLE;
        end
      end

      // Timeout abandons the packet; writes already issued stand.
      if (!timed || rx_new) begin
        tmo <= '0;
      end else if (tmo_hit) begin
        tmo   <= '0;
        err   <= 1'b1;
        state <= IDLE;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule
